cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_arbiter_if.sv | 27 ++
 rtl/cdb_arbiter_src_fifo.sv | 57 +++++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU result-bus types: ROB id/data widths, producer indices and the queued CDB entry.
// Pure declarations: no latency and no flow control.
package cdb_arbiter_pkg;

    localparam int ROB_W   = 5;
    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_BRU = 2;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_id;
        logic [DATA_W-1:0] value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: packed per-source results, per-source full, broadcast outputs.
// Wires only; producers must honour src_full before pushing.
interface cdb_arbiter_if #(
    parameter int NUM_SRC = cdb_arbiter_pkg::NUM_SRC
);

    logic                                          clear;
    logic [NUM_SRC-1:0]                            src_ready;
    logic [cdb_arbiter_pkg::ROB_W*NUM_SRC-1:0]     src_rob_id;
    logic [cdb_arbiter_pkg::DATA_W*NUM_SRC-1:0]    src_value;
    logic [NUM_SRC-1:0]                            src_full;
    logic                                          overflow;
    logic                                          cdb_ready;
    logic [cdb_arbiter_pkg::ROB_W-1:0]             cdb_rob_id;
    logic [cdb_arbiter_pkg::DATA_W-1:0]            cdb_value;

    modport master (
        output clear, src_ready, src_rob_id, src_value,
        input  src_full, overflow, cdb_ready, cdb_rob_id, cdb_value
    );

    modport slave (
        input  clear, src_ready, src_rob_id, src_value,
        output src_full, overflow, cdb_ready, cdb_rob_id, cdb_value
    );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result queue, DEPTH entries; head is visible combinationally (0-cycle read).
// Push when full is accepted only alongside a pop; otherwise the caller sees it dropped.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t push_dat,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cdb_entry_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_in) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter over per-source FIFOs with empty-FIFO bypass.
// Latency 1 cycle (bypass), +1 per queued entry ahead; rdy_in=0 freezes, src_full backpressures.
module cdb_arbiter #(
    parameter int NUM_SRC = cdb_arbiter_pkg::NUM_SRC,
    parameter int DEPTH   = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    cdb_arbiter_if.slave bus
);

    import cdb_arbiter_pkg::*;

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    cdb_entry_t         in_dat   [NUM_SRC];
    cdb_entry_t         head_dat [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] push_req;
    logic [NUM_SRC-1:0] pop_req;
    logic [NUM_SRC-1:0] ovf_evt;
    logic               active;
    logic               flush;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   last_grant;
    cdb_entry_t         win_dat;
    int                 scan;

    logic               cdb_ready_q;
    cdb_entry_t         cdb_q;
    logic               overflow_q;

    assign active = rdy_in & ~bus.clear;
    assign flush  = rdy_in & bus.clear;
    assign cand   = ~fifo_empty | bus.src_ready;

    // First candidate at or after last_grant+1, wrapping at NUM_SRC.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan = int'(last_grant) + 1 + k;
            if (scan >= NUM_SRC) scan = scan - NUM_SRC;
            if (!grant_vld && cand[scan[SEL_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        win_dat = in_dat[grant_idx];
        if (!fifo_empty[grant_idx]) win_dat = head_dat[grant_idx];
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic granted;

        assign in_dat[i] = '{rob_id: bus.src_rob_id[ROB_W*i +: ROB_W],
                             value:  bus.src_value[DATA_W*i +: DATA_W]};
        assign granted     = grant_vld && (grant_idx == SEL_W'(i));
        assign pop_req[i]  = active & granted & ~fifo_empty[i];
        // A granted source with an empty FIFO is served straight from its input.
        assign push_req[i] = active & bus.src_ready[i] & ~(granted & fifo_empty[i]);
        assign ovf_evt[i]  = push_req[i] & fifo_full[i] & ~pop_req[i];

        cdb_src_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .flush    (flush),
            .push     (push_req[i]),
            .pop      (pop_req[i]),
            .push_dat (in_dat[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .head     (head_dat[i])
        );
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_ready_q <= 1'b0;
            cdb_q       <= '0;
            overflow_q  <= 1'b0;
            last_grant  <= SEL_W'(NUM_SRC - 1);
        end else if (rdy_in) begin
            if (bus.clear) begin
                cdb_ready_q <= 1'b0;
            end else begin
                cdb_ready_q <= grant_vld;
                if (grant_vld) begin
                    cdb_q      <= win_dat;
                    last_grant <= grant_idx;
                end
                if (|ovf_evt) overflow_q <= 1'b1;
            end
        end
    end

    assign bus.src_full   = fifo_full;
    assign bus.overflow   = overflow_q;
    assign bus.cdb_ready  = cdb_ready_q;
    assign bus.cdb_rob_id = cdb_q.rob_id;
    assign bus.cdb_value  = cdb_q.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: bypass, contention, fairness, overflow, clear, freeze, reset.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(3)) bus ();

    cdb_arbiter #(
        .NUM_SRC (3),
        .DEPTH   (2)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    typedef struct {
        bit       rst_b;
        bit       rdy;
        bit       clr;
        bit [2:0] vld;
        bit [4:0] r0;
        bit [4:0] r1;
        bit [4:0] r2;
        bit       e_vld;
        bit [4:0] e_rob;
        bit [2:0] e_full;
        bit       e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] val_of(logic [4:0] r);
        return {3'b0, r, 3'b0, r, 3'b0, r, 3'b0, r};
    endfunction

    function automatic vec_t mk(bit rb, bit rd, bit cl, bit [2:0] v, bit [4:0] a, bit [4:0] b,
                                bit [4:0] c, bit ev, bit [4:0] er, bit [2:0] ef, bit eo);
        vec_t t;
        t.rst_b = rb; t.rdy = rd; t.clr = cl; t.vld = v;
        t.r0 = a; t.r1 = b; t.r2 = c;
        t.e_vld = ev; t.e_rob = er; t.e_full = ef; t.e_ovf = eo;
        return t;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic check_out(int row, bit ev, bit [4:0] er, bit [2:0] ef, bit eo);
        chk("cdb_ready",  row, 32'(bus.cdb_ready),  32'(ev));
        chk("cdb_rob_id", row, 32'(bus.cdb_rob_id), 32'(er));
        chk("cdb_value",  row, bus.cdb_value,       val_of(er));
        chk("src_full",   row, 32'(bus.src_full),   32'(ef));
        chk("overflow",   row, 32'(bus.overflow),   32'(eo));
    endtask

    task automatic drive(vec_t v);
        rdy            = v.rdy;
        bus.clear      = v.clr;
        bus.src_ready  = v.vld;
        bus.src_rob_id = {v.r2, v.r1, v.r0};
        bus.src_value  = {val_of(v.r2), val_of(v.r1), val_of(v.r0)};
    endtask

    // Called at a falling edge: reset must clear outputs without waiting for a clock.
    task automatic do_reset(int row);
        rst = 1'b1;
        #1;
        check_out(1000 + row, 1'b0, 5'd0, 3'b000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(mk(0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

        // rst_b rdy clr vld r0 r1 r2 | e_vld e_rob e_full e_ovf
        // Single bypass
        tbl.push_back(mk(0, 1, 0, 3'b001,  3,  0,  0, 1,  3, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0,  3, 3'b000, 0));
        // Contention after reset
        tbl.push_back(mk(1, 1, 0, 3'b111,  1,  2,  3, 1,  1, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1,  2, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1,  3, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0,  3, 3'b000, 0));
        // Fairness: ALU and LSB push each cycle unless shown full
        tbl.push_back(mk(1, 1, 0, 3'b011, 10, 20,  0, 1, 10, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b011, 11, 21,  0, 1, 20, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b011, 12, 22,  0, 1, 11, 3'b010, 0));
        tbl.push_back(mk(0, 1, 0, 3'b001, 13,  0,  0, 1, 21, 3'b001, 0));
        tbl.push_back(mk(0, 1, 0, 3'b010,  0, 23,  0, 1, 12, 3'b010, 0));
        tbl.push_back(mk(0, 1, 0, 3'b001, 14,  0,  0, 1, 22, 3'b001, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 13, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 23, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 14, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0, 14, 3'b000, 0));
        // Overflow on BRU: entry 33 is dropped
        tbl.push_back(mk(1, 1, 0, 3'b101,  1,  0, 30, 1,  1, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b110,  0,  2, 31, 1,  2, 3'b100, 0));
        tbl.push_back(mk(0, 1, 0, 3'b100,  0,  0, 32, 1, 30, 3'b100, 0));
        tbl.push_back(mk(0, 1, 0, 3'b101,  4,  0, 33, 1,  4, 3'b100, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 31, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 32, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0, 32, 3'b000, 1));
        // Clear with two queued entries and a same-cycle push
        tbl.push_back(mk(0, 1, 0, 3'b111,  5,  6,  7, 1,  5, 3'b000, 1));
        tbl.push_back(mk(0, 1, 1, 3'b111,  8,  9, 10, 0,  5, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0,  5, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0,  5, 3'b000, 1));
        // Freeze with ALU full, then resume
        tbl.push_back(mk(0, 1, 0, 3'b011, 11, 12,  0, 1, 12, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b011, 13, 14,  0, 1, 11, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b011, 15, 16,  0, 1, 14, 3'b001, 1));
        tbl.push_back(mk(0, 0, 0, 3'b111, 17, 18, 19, 1, 14, 3'b001, 1));
        tbl.push_back(mk(0, 0, 1, 3'b111, 17, 18, 19, 1, 14, 3'b001, 1));
        tbl.push_back(mk(0, 0, 0, 3'b111, 17, 18, 19, 1, 14, 3'b001, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 13, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 16, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 15, 3'b000, 1));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0, 15, 3'b000, 1));
        // Queue entries, then reset mid-burst: they must be lost
        tbl.push_back(mk(0, 1, 0, 3'b111, 20, 21, 22, 1, 21, 3'b000, 1));
        tbl.push_back(mk(1, 1, 0, 3'b011, 25, 26,  0, 1, 25, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 1, 26, 3'b000, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000,  0,  0,  0, 0, 26, 3'b000, 0));

        @(negedge clk);
        @(negedge clk);
        check_out(0, 1'b0, 5'd0, 3'b000, 1'b0);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst_b) do_reset(r + 1);
            drive(tbl[r]);
            @(posedge clk);
            @(negedge clk);
            check_out(r + 1, tbl[r].e_vld, tbl[r].e_rob, tbl[r].e_full, tbl[r].e_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
